// File: rtl/cal_eep_spi_slave_if.sv
// SPI bus and write-report signals between the command processor's SPI master
// (or a testbench) and the calibration EEPROM model.
interface cal_eep_spi_slave_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              SS_n;
  logic              SCLK;
  logic              MOSI;
  logic              MISO;
  logic              wr_pulse;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              frame_err;

  modport master (
    output SS_n, SCLK, MOSI,
    input  MISO, wr_pulse, wr_addr, wr_data, frame_err
  );

  modport slave (
    input  SS_n, SCLK, MOSI,
    output MISO, wr_pulse, wr_addr, wr_data, frame_err
  );
endinterface

// File: rtl/cal_eep_spi_slave.sv
// SPI responder modelling the 64x8 calibration EEPROM on the ss[2] line.
// 16-bit frames, MSB first: [15:14] opcode (01 write, 00 read, 1x reserved),
// [13:8] address, [7:0] data. A read is answered in the low byte of the
// following frame.
module cal_eep_spi_slave #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 8,
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  cal_eep_spi_slave_if.slave spi
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W + 1);

  typedef enum logic [1:0] {
    ARM    = 2'd0,
    IDLE   = 2'd1,
    SHIFT  = 2'd2,
    DECODE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // --- stage p0/p1: two-flop synchronisers, p2: previous value for edges ---
  logic ss_n_p0, ss_n_p1, ss_n_p2;
  logic sclk_p0, sclk_p1, sclk_p2;
  logic mosi_p0, mosi_p1;

  logic ss_fall, ss_rise, sclk_rise, sclk_fall;

  logic [1:0]         arm_cnt;
  logic               sync_primed;

  logic [FRAME_W-1:0] tx_shift;
  logic [FRAME_W-1:0] rx_shift;
  logic [CNT_W-1:0]   bit_cnt;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  rd_buf;

  logic [1:0]         rx_op;
  logic [ADDR_W-1:0]  rx_addr;
  logic [DATA_W-1:0]  rx_data;

  // Bring the asynchronous SPI inputs into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_n_p0 <= 1'b1;
      ss_n_p1 <= 1'b1;
      ss_n_p2 <= 1'b1;
      sclk_p0 <= 1'b1;
      sclk_p1 <= 1'b1;
      sclk_p2 <= 1'b1;
      mosi_p0 <= 1'b1;
      mosi_p1 <= 1'b1;
    end else begin
      ss_n_p0 <= spi.SS_n;
      ss_n_p1 <= ss_n_p0;
      ss_n_p2 <= ss_n_p1;
      sclk_p0 <= spi.SCLK;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      mosi_p0 <= spi.MOSI;
      mosi_p1 <= mosi_p0;
    end
  end

  // --- stage p1/p2 boundary: edge strobes on synchronised signals ---
  assign ss_fall   =  ss_n_p2 & ~ss_n_p1;
  assign ss_rise   = ~ss_n_p2 &  ss_n_p1;
  assign sclk_rise = ~sclk_p2 &  sclk_p1;
  assign sclk_fall =  sclk_p2 & ~sclk_p1;

  // The sync flops come out of reset at 1, so ss_n_p1 only reflects the real
  // pin two clocks after release; ARM waits for that before trusting SS_n high,
  // otherwise a frame in progress at reset release would be picked up halfway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_cnt <= 2'd0;
    end else if (arm_cnt != 2'd3) begin
      arm_cnt <= arm_cnt + 2'd1;
    end
  end

  assign sync_primed = (arm_cnt == 2'd3);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARM:     if (sync_primed && ss_n_p1) state_d = IDLE;
      IDLE:    if (ss_fall)                state_d = SHIFT;
      SHIFT:   if (ss_rise)                state_d = DECODE;
      DECODE:                              state_d = IDLE;
      default:                             state_d = ARM;
    endcase
  end

  // Shift registers and bit counter; a fall before any rise is the master's
  // leading edge and must not disturb bit 15, which is already on MISO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else if (state_q == IDLE && ss_fall) begin
      tx_shift <= {{(FRAME_W - DATA_W){1'b0}}, rd_buf};
      bit_cnt  <= '0;
    end else if (state_q == SHIFT) begin
      if (sclk_rise) begin
        rx_shift <= {rx_shift[FRAME_W-2:0], mosi_p1};
        if (bit_cnt != CNT_MAX) begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
      if (sclk_fall && bit_cnt != '0) begin
        tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
      end
    end
  end

  // --- stage p2/decode boundary: frame fields ---
  assign rx_op   = rx_shift[FRAME_W-1 -: 2];
  assign rx_addr = rx_shift[FRAME_W-3 -: ADDR_W];
  assign rx_data = rx_shift[DATA_W-1:0];

  // Commit a completed frame: write to memory or capture read data; a frame of
  // the wrong length only raises frame_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_buf        <= '0;
      spi.wr_pulse  <= 1'b0;
      spi.wr_addr   <= '0;
      spi.wr_data   <= '0;
      spi.frame_err <= 1'b0;
    end else begin
      spi.wr_pulse  <= 1'b0;
      spi.frame_err <= 1'b0;
      if (state_q == DECODE) begin
        if (bit_cnt == FRAME_CNT) begin
          case (rx_op)
            2'b01: begin
              mem[rx_addr] <= rx_data;
              spi.wr_pulse <= 1'b1;
              spi.wr_addr  <= rx_addr;
              spi.wr_data  <= rx_data;
            end
            2'b00:   rd_buf <= mem[rx_addr];
            default: ;
          endcase
        end else begin
          spi.frame_err <= 1'b1;
        end
      end
    end
  end

  // MISO is driven only while selected and shifting.
  assign spi.MISO = (state_q == SHIFT && !ss_n_p1) ? tx_shift[FRAME_W-1] : 1'b0;

endmodule

// File: tb/tb_cal_eep_spi_slave.sv
// Directed bench for the calibration EEPROM SPI model.
module tb_cal_eep_spi_slave;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cal_eep_spi_slave_if #(.ADDR_W(6), .DATA_W(8)) bus ();

  cal_eep_spi_slave #(.ADDR_W(6), .DATA_W(8), .FRAME_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .spi   (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int wr_tot = 0;
  int err_tot = 0;

  // Running totals of the single-cycle pulses, sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.wr_pulse === 1'b1)  wr_tot++;
    if (bus.frame_err === 1'b1) err_tot++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCLK period: fall (MOSI changes), capture MISO just before the rise.
  task automatic spi_bit(input logic b, inout logic [15:0] rx);
    bus.SCLK = 1'b0;
    bus.MOSI = b;
    wait_clk(5);
    rx = {rx[14:0], bus.MISO};
    bus.SCLK = 1'b1;
    wait_clk(5);
  endtask

  task automatic frame(input logic [31:0] word, input int nbits, output logic [15:0] rx);
    rx = '0;
    bus.SS_n = 1'b0;
    wait_clk(6);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_bit(word[i], rx);
    end
    wait_clk(3);
    bus.SS_n = 1'b1;
    wait_clk(10);
  endtask

  // Full 16-bit frame with MISO and pulse-count expectations.
  task automatic xfer(input string tag, input logic [15:0] word, input logic [15:0] exp_miso,
                      input int exp_wr, input int exp_err);
    logic [15:0] rx;
    int w0, e0;
    w0 = wr_tot;
    e0 = err_tot;
    frame({16'h0, word}, 16, rx);
    chk({tag, "_miso"}, {16'h0, rx}, {16'h0, exp_miso});
    chk({tag, "_wr"},   wr_tot - w0, exp_wr);
    chk({tag, "_err"},  err_tot - e0, exp_err);
  endtask

  initial begin
    logic [15:0] rx;
    int w0, e0;

    bus.SS_n = 1'b1;
    bus.SCLK = 1'b1;
    bus.MOSI = 1'b0;
    rst_n    = 1'b0;
    wait_clk(5);
    chk("rst_miso",  {31'h0, bus.MISO},      32'h0);
    chk("rst_wrp",   {31'h0, bus.wr_pulse},  32'h0);
    chk("rst_err",   {31'h0, bus.frame_err}, 32'h0);
    chk("rst_waddr", {26'h0, bus.wr_addr},   32'h0);
    chk("rst_wdata", {24'h0, bus.wr_data},   32'h0);
    rst_n = 1'b1;
    wait_clk(10);

    // Write then read.
    xfer("wr0a", 16'h4A37, 16'h0000, 1, 0);
    chk("wr0a_addr", {26'h0, bus.wr_addr}, 32'h0A);
    chk("wr0a_data", {24'h0, bus.wr_data}, 32'h37);
    xfer("rd0a",  16'h0A00, 16'h0000, 0, 0);
    xfer("ret0a", 16'hBCBC, 16'h0037, 0, 0);

    // Back-to-back reads.
    xfer("wr01", 16'h4111, 16'h0037, 1, 0);
    xfer("wr02", 16'h4222, 16'h0037, 1, 0);
    xfer("rd01", 16'h0100, 16'h0037, 0, 0);
    xfer("rd02", 16'h0200, 16'h0011, 0, 0);
    xfer("ret02", 16'hBCBC, 16'h0022, 0, 0);

    // Short frame: write opcode to addr 5 with only 12 bits.
    w0 = wr_tot; e0 = err_tot;
    frame(32'h45F, 12, rx);
    chk("short_err", err_tot - e0, 1);
    chk("short_wr",  wr_tot - w0,  0);
    xfer("rd05",  16'h0500, 16'h0022, 0, 0);
    xfer("ret05", 16'hBCBC, 16'h0000, 0, 0);

    // Long frame: 20 bits.
    w0 = wr_tot; e0 = err_tot;
    frame(32'h4A5FF, 20, rx);
    chk("long_err", err_tot - e0, 1);
    chk("long_wr",  wr_tot - w0,  0);

    // Reserved opcode leaves rd_buf alone; a write to the buffered address does not refresh it.
    xfer("rd0a_b", 16'h0A00, 16'h0000, 0, 0);
    xfer("resv",   16'hC5FF, 16'h0037, 0, 0);
    xfer("postrv", 16'hBCBC, 16'h0037, 0, 0);
    xfer("wr0a_b", 16'h4A99, 16'h0037, 1, 0);
    xfer("noretro", 16'hBCBC, 16'h0037, 0, 0);

    // Address boundaries.
    xfer("wr3f",  16'h7FA5, 16'h0037, 1, 0);
    chk("wr3f_addr", {26'h0, bus.wr_addr}, 32'h3F);
    xfer("wr00",  16'h405A, 16'h0037, 1, 0);
    chk("wr00_addr", {26'h0, bus.wr_addr}, 32'h00);
    xfer("rd3f",  16'h3F00, 16'h0037, 0, 0);
    xfer("rd00",  16'h0000, 16'h00A5, 0, 0);
    xfer("ret00", 16'hBCBC, 16'h005A, 0, 0);

    // Reset mid-frame: 8 bits, reset with SS_n low, then finish the frame.
    w0 = wr_tot; e0 = err_tot;
    rx = '0;
    bus.SS_n = 1'b0;
    wait_clk(6);
    for (int i = 15; i >= 8; i--) begin
      spi_bit(1'(16'h4177 >> i), rx);
    end
    rst_n = 1'b0;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    for (int i = 7; i >= 0; i--) begin
      spi_bit(1'(16'h4177 >> i), rx);
    end
    wait_clk(3);
    bus.SS_n = 1'b1;
    wait_clk(10);
    chk("rstmid_wr",  wr_tot - w0,  0);
    chk("rstmid_err", err_tot - e0, 0);
    xfer("wr01_b", 16'h4155, 16'h0000, 1, 0);
    chk("wr01_b_data", {24'h0, bus.wr_data}, 32'h55);
    xfer("rd3f_b", 16'h3F00, 16'h0000, 0, 0);
    xfer("rd01_b", 16'h0100, 16'h0000, 0, 0);
    xfer("ret01",  16'hBCBC, 16'h0055, 0, 0);

    // SS_n glitch with no SCLK edges.
    w0 = wr_tot; e0 = err_tot;
    bus.SS_n = 1'b0;
    wait_clk(6);
    bus.SS_n = 1'b1;
    wait_clk(10);
    chk("glitch_err", err_tot - e0, 1);
    chk("glitch_wr",  wr_tot - w0,  0);
    chk("idle_miso",  {31'h0, bus.MISO}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cal_eep_spi_slave.md
Name: cal_eep_spi_slave

Overview:
- SPI responder that models the 64x8 calibration EEPROM on the `ss[2]` chip-select line of the scope front end.
- Accepts 16-bit frames from the command processor's SPI master, which issues EEPROM write and read commands.
- Answers reads on the following frame, which is how the master obtains `EEP_data`.
- Used in the full-chip testbench and in FPGA builds without a physical EEPROM.

Parameters:
- ADDR_W, 6, EEPROM address width; depth is 2**ADDR_W.
- DATA_W, 8, EEPROM word width.
- FRAME_W, 16, bits per SPI frame.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- SS_n  input  1  chip select from master, active low
- SCLK  input  1  SPI clock from master, idles high
- MOSI  input  1  master-out data, MSB first
- MISO  output  1  slave-out data, MSB first
- wr_pulse  output  1  one-clk pulse when a write commits
- wr_addr  output  ADDR_W  address of the last committed write
- wr_data  output  DATA_W  data of the last committed write
- frame_err  output  1  one-clk pulse when a frame ends with a bit count other than FRAME_W

Behaviour:
- Synchronisation:
  - SS_n, SCLK and MOSI each pass through a 2-flop synchroniser; sync flops reset to 1.
  - Edges are detected on the synchronised signals.
  - Master guarantees SCLK half-period of at least 4 clk, and at least 4 clk between SS_n fall and the first SCLK fall.
- Bit timing:
  - MISO shifts on the synchronised SCLK falling edge.
  - MOSI is sampled on the synchronised SCLK rising edge.
- Frame format, MSB first:
  - [15:14] opcode: 2'b01 write, 2'b00 read, 2'b1x reserved.
  - [13:8] address.
  - [7:0] write data; don't-care for read.
- State machine:
  - ARM: after reset, wait until synchronised SS_n = 1, then go to IDLE. A frame already in progress at reset release is ignored.
  - IDLE: on SS_n falling edge, load tx_shift = {8'h00, rd_buf}, clear bit_cnt, go to SHIFT.
  - SHIFT:
    - Each SCLK rise: rx_shift <= {rx_shift[14:0], MOSI}; bit_cnt increments, saturating at FRAME_W+1.
    - Each SCLK fall after the first rise: tx_shift shifts left with 0 fill.
    - On SS_n rising edge, go to DECODE.
  - DECODE: one clk, then return to IDLE.
    - If bit_cnt == FRAME_W and opcode 01: mem[addr] <= data; wr_pulse = 1; wr_addr/wr_data updated.
    - If bit_cnt == FRAME_W and opcode 00: rd_buf <= mem[addr].
    - Reserved opcode: no action, no error.
    - If bit_cnt != FRAME_W: frame_err = 1; mem and rd_buf unchanged.
- MISO:
  - Equals tx_shift[15] while synchronised SS_n = 0 and state is SHIFT; otherwise 0.
  - Bit 15 is valid before the first SCLK fall.
- Read latency: data read by frame N is returned in bits [7:0] of frame N+1, whatever frame N+1's command is. The upper byte is always 8'h00.
- Frame N+1 may itself be a read; it returns frame N's data and then updates rd_buf.
- A write to the address held in rd_buf does not retro-update rd_buf.
- Reset values:
  - mem all 0, rd_buf 0, tx/rx shift 0, bit_cnt 0.
  - wr_pulse 0, wr_addr 0, wr_data 0, frame_err 0, MISO 0.
  - State ARM.
- Reset asserted mid-frame aborts the frame, with no write or error pulse. The block re-arms only after SS_n is seen high.
- SS_n glitch with zero SCLK edges: bit_cnt 0, so frame_err pulses.

Test Plan:
- Write then read:
  - Frames 16'h4A37 (write addr 0x0A, data 0x37), then 16'h0A00 (read 0x0A), then 16'hBCBC.
  - wr_pulse once with wr_addr=0x0A, wr_data=0x37.
  - Third frame's MISO = 16'h0037; second frame's MISO = 16'h0000.
- Back-to-back reads:
  - Prior writes mem[1]=0x11, mem[2]=0x22.
  - Send 16'h0100, 16'h0200, 16'hBCBC.
  - Frames 2 and 3 return 16'h0011 and 16'h0022.
- Short and long frames:
  - 12-bit frame with write opcode to addr 5 -> frame_err pulse, no wr_pulse, mem[5] still 0.
  - 20-bit frame -> frame_err pulse, no write.
- Reserved opcode:
  - Frame 16'hC5FF -> no wr_pulse, no frame_err, rd_buf unchanged on next frame.
- Reset mid-frame:
  - Assert rst_n low after 8 bits with SS_n held low, release, finish that frame -> no write, no error.
  - Next full frame 16'h4155 -> wr_pulse, mem[1]=0x55.
- Address boundaries:
  - Write 0x3F data 0xA5 and 0x00 data 0x5A, then read both.
  - Readbacks 16'h00A5 and 16'h005A; no aliasing.
